// File: rtl/echo_display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// echo_display_scan_ctrl_pkg
// Shared definitions for the multiplexed 7-segment scan controller:
//   SYM_W      - symbol width seen by the shared decoder (S1..S5, S1 = MSB)
//   BLANK_SYM  - symbol loaded into the shadow and active buffers at reset
//   state_t    - scan FSM encoding (IDLE / BLANK / SHOW)
//   clog2()    - ceiling log2, used to size address and counter fields
// -----------------------------------------------------------------------------
package echo_display_scan_ctrl_pkg;

   localparam int SYM_W = 5;
   localparam logic [SYM_W-1:0] BLANK_SYM = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   // Smallest r with 2**r >= n.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/echo_display_scan_ctrl_timer.sv
// -----------------------------------------------------------------------------
// echo_scan_timer
// Dwell counter for the scan FSM. A load pulse starts a dwell of either
// SHOW_CYCLES (sel_show=1) or BLANK_CYCLES (sel_show=0); done is high during
// the last cycle of that dwell.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - start a new dwell at this edge
//   sel_show    - dwell length select for the load (1 = SHOW, 0 = BLANK)
//   done        - last cycle of the current dwell
// -----------------------------------------------------------------------------
module echo_scan_timer
   import echo_display_scan_ctrl_pkg::*;
#(
   parameter int SHOW_CYCLES  = 1000,
   parameter int BLANK_CYCLES = 8
)(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic sel_show,
   output logic done
);

   localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CNT_W      = clog2(MAX_CYCLES + 1);

   // The counter holds "cycles remaining after this one", so a dwell of N
   // cycles is loaded as N-1 and done is simply count == 0.
   localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= sel_show ? SHOW_LOAD : BLANK_LOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/echo_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// echo_display_scan_ctrl
// Time-multiplexes one shared 7-segment symbol decoder across N_DIGITS
// common-select digits. Each digit visit is BLANK_CYCLES of all-digits-off
// followed by SHOW_CYCLES with that digit lit. Upstream writes land in a
// shadow buffer; the shadow is copied to the active (displayed) buffer only
// at frame boundaries, or continuously while the scan is disabled.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   en          - scan enable; 0 forces all digits off and parks at IDLE
//   wr_valid/wr_ready/wr_addr/wr_sym - shadow buffer write port
//   wr_err      - one-cycle pulse after an accepted out-of-range write
//   sym_out     - symbol to the shared decoder, stable over BLANK+SHOW
//   digit_en    - one-hot digit select, zero while blanking or idle
//   scan_idx    - digit currently being serviced
//   frame_tick  - one-cycle pulse when scan_idx wraps to 0
//   fsm_state   - current scan state (IDLE/BLANK/SHOW encoding)
//
// Write handshake: a write transfers on every rising edge where wr_valid and
// wr_ready are both high; wr_valid may be held across stalled cycles and the
// write fields must be stable while wr_valid is high. wr_ready is low only in
// the cycle that frame_tick is high.
// -----------------------------------------------------------------------------
module echo_display_scan_ctrl
   import echo_display_scan_ctrl_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int SHOW_CYCLES  = 1000,
   parameter int BLANK_CYCLES = 8
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [clog2(N_DIGITS)-1:0]  wr_addr,
   input  logic [SYM_W-1:0]            wr_sym,
   output logic                        wr_err,
   output logic [SYM_W-1:0]            sym_out,
   output logic [N_DIGITS-1:0]         digit_en,
   output logic [clog2(N_DIGITS)-1:0]  scan_idx,
   output logic                        frame_tick,
   output logic [1:0]                  fsm_state
);

   localparam int AW = clog2(N_DIGITS);
   localparam logic [N_DIGITS-1:0] DIGIT0 = N_DIGITS'(1);

   state_t           state;
   logic [SYM_W-1:0] shadow     [N_DIGITS];
   logic [SYM_W-1:0] active     [N_DIGITS];
   logic [SYM_W-1:0] commit_val [N_DIGITS];
   logic             dirty;

   logic             wr_fire;
   logic             wr_in_range;
   logic             last_idx;
   logic [AW-1:0]    next_idx;
   logic             frame_wrap;
   logic             commit_now;
   logic             commit_any;
   logic             timer_load;
   logic             timer_sel_show;
   logic             timer_done;

   assign wr_fire     = wr_valid & wr_ready;
   assign wr_in_range = wr_fire && (32'(wr_addr) < 32'(N_DIGITS));

   assign last_idx   = (scan_idx == AW'(N_DIGITS - 1));
   assign next_idx   = last_idx ? '0 : scan_idx + 1'b1;
   assign frame_wrap = en && (state == SHOW) && timer_done && last_idx;

   // Commits happen at the frame boundary and on every disabled cycle, so the
   // next enable always starts from current data.
   assign commit_now = !en || frame_wrap;
   assign commit_any = commit_now && (dirty || wr_in_range);

   // A write accepted on the same edge as a commit is folded into the copy
   // instead of being lost between shadow and active.
   always_comb begin
      for (int i = 0; i < N_DIGITS; i++) begin
         commit_val[i] = (wr_in_range && (wr_addr == AW'(i))) ? wr_sym : shadow[i];
      end
   end

   // Timer reload on every entry into BLANK or SHOW.
   assign timer_load     = en && ((state == IDLE) || (state != IDLE && timer_done));
   assign timer_sel_show = (state == BLANK);

   echo_scan_timer #(
      .SHOW_CYCLES  (SHOW_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .sel_show (timer_sel_show),
      .done     (timer_done)
   );

   // Shadow / active buffers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            shadow[i] <= BLANK_SYM;
            active[i] <= BLANK_SYM;
         end
         dirty <= 1'b0;
      end else begin
         if (wr_in_range) shadow[wr_addr] <= wr_sym;
         if (commit_any) begin
            for (int i = 0; i < N_DIGITS; i++) active[i] <= commit_val[i];
            dirty <= 1'b0;
         end else if (wr_in_range) begin
            dirty <= 1'b1;
         end
      end
   end

   // Scan FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         digit_en   <= '0;
         scan_idx   <= '0;
         sym_out    <= BLANK_SYM;
         frame_tick <= 1'b0;
         wr_err     <= 1'b0;
         wr_ready   <= 1'b1;
      end else begin
         frame_tick <= frame_wrap;
         wr_ready   <= !frame_wrap;
         wr_err     <= wr_fire && !wr_in_range;
         if (!en) begin
            state    <= IDLE;
            digit_en <= '0;
            scan_idx <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= BLANK;
                  digit_en <= '0;
                  scan_idx <= '0;
                  sym_out  <= active[0];
               end
               BLANK: begin
                  if (timer_done) begin
                     state    <= SHOW;
                     digit_en <= DIGIT0 << scan_idx;
                  end
               end
               SHOW: begin
                  if (timer_done) begin
                     state    <= BLANK;
                     digit_en <= '0;
                     scan_idx <= next_idx;
                     // sym_out only moves on BLANK entry; at the wrap it must
                     // see the buffer being committed on this same edge.
                     if (last_idx) sym_out <= commit_any ? commit_val[0] : active[0];
                     else          sym_out <= active[next_idx];
                  end
               end
               default: begin
                  state    <= IDLE;
                  digit_en <= '0;
               end
            endcase
         end
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_echo_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_echo_display_scan_ctrl
// Bench for echo_display_scan_ctrl (N_DIGITS=4, SHOW_CYCLES=3, BLANK_CYCLES=1)
// plus a second N_DIGITS=5 instance whose 3-bit address can go out of range.
// The reference model tracks the position inside the frame and the two symbol
// buffers; outputs are derived from that position arithmetically.
// -----------------------------------------------------------------------------
module tb_echo_display_scan_ctrl;
   import echo_display_scan_ctrl_pkg::*;

   localparam int N = 4;
   localparam int S = 3;
   localparam int B = 1;
   localparam int D = B + S;
   localparam int P = N * D;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             en;
   logic             wr_valid;
   logic [1:0]       wr_addr;
   logic [SYM_W-1:0] wr_sym;
   logic             wr_ready;
   logic             wr_err;
   logic [SYM_W-1:0] sym_out;
   logic [3:0]       digit_en;
   logic [1:0]       scan_idx;
   logic             frame_tick;
   logic [1:0]       fsm_state;

   logic             en2;
   logic             wr_valid2;
   logic [2:0]       wr_addr2;
   logic [SYM_W-1:0] wr_sym2;
   logic             wr_ready2;
   logic             wr_err2;
   logic [SYM_W-1:0] sym_out2;
   logic [4:0]       digit_en2;
   logic [2:0]       scan_idx2;
   logic             frame_tick2;
   logic [1:0]       fsm_state2;

   echo_display_scan_ctrl #(.N_DIGITS(N), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_sym(wr_sym),
      .wr_err(wr_err), .sym_out(sym_out), .digit_en(digit_en), .scan_idx(scan_idx),
      .frame_tick(frame_tick), .fsm_state(fsm_state)
   );

   echo_display_scan_ctrl #(.N_DIGITS(5), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en2),
      .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_addr(wr_addr2), .wr_sym(wr_sym2),
      .wr_err(wr_err2), .sym_out(sym_out2), .digit_en(digit_en2), .scan_idx(scan_idx2),
      .frame_tick(frame_tick2), .fsm_state(fsm_state2)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [SYM_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit               m_started = 1'b0;
   bit               m_run;
   int               m_pos;
   logic [SYM_W-1:0] m_shadow [N];
   logic [SYM_W-1:0] m_active [N];
   logic [SYM_W-1:0] m_sym;
   bit               m_tick;
   bit               m_ready;
   bit               m_err;

   task automatic model_step();
      bit acc;
      bit oor;
      acc = wr_valid && m_ready;
      oor = (int'(wr_addr) >= N);
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_shadow[i] = BLANK_SYM;
            m_active[i] = BLANK_SYM;
         end
         m_run = 0; m_pos = 0; m_sym = BLANK_SYM;
         m_tick = 0; m_ready = 1; m_err = 0;
         return;
      end
      m_err = acc && oor;
      if (acc && !oor) m_shadow[wr_addr] = wr_sym;
      m_tick = 0;
      if (!en) begin
         m_run = 0;
         m_pos = 0;
         m_active = m_shadow;
      end else if (!m_run) begin
         m_run = 1;
         m_pos = 0;
         m_sym = m_active[0];
      end else begin
         m_pos = (m_pos + 1) % P;
         if (m_pos == 0) begin
            m_tick = 1;
            m_active = m_shadow;
         end
         if (m_pos % D == 0) m_sym = m_active[m_pos / D];
      end
      m_ready = !m_tick;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
      m_started = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   logic [SYM_W-1:0] prev_sym = '0;

   initial forever begin
      logic [3:0] e_de;
      logic [1:0] e_idx;
      logic [1:0] e_st;
      @(negedge clk);
      if (m_started) begin
         e_de  = (m_run && (m_pos % D) >= B) ? 4'(4'b0001 << (m_pos / D)) : 4'b0000;
         e_idx = m_run ? 2'(m_pos / D) : 2'd0;
         e_st  = !m_run ? 2'd0 : (((m_pos % D) < B) ? 2'd1 : 2'd2);
         check("m_digit_en",   32'(digit_en),   32'(e_de));
         check("m_scan_idx",   32'(scan_idx),   32'(e_idx));
         check("m_state",      32'(fsm_state),  32'(e_st));
         check("m_sym_out",    32'(sym_out),    32'(m_sym));
         check("m_frame_tick", 32'(frame_tick), 32'(m_tick));
         check("m_wr_ready",   32'(wr_ready),   32'(m_ready));
         check("m_wr_err",     32'(wr_err),     32'(m_err));
         check("onehot0",      32'($onehot0(digit_en)), 32'd1);
         if (sym_out != prev_sym) check("dark_on_sym_change", 32'(digit_en), 32'd0);
         prev_sym = sym_out;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_de(input logic [3:0] v, input int bound);
      bit hit;
      hit = 0;
      for (int i = 0; i < bound && !hit; i++) begin
         @(negedge clk);
         if (digit_en == v) hit = 1;
      end
      check("wait_digit_en", 32'(hit), 32'd1);
   endtask

   task automatic wait_tick(input int bound, output int n);
      bit hit;
      hit = 0;
      n = 0;
      while (n < bound && !hit) begin
         @(negedge clk);
         n++;
         if (frame_tick) hit = 1;
      end
      check("wait_tick", 32'(hit), 32'd1);
   endtask

   task automatic expect_sym(input logic [3:0] de, input string name);
      logic [SYM_W-1:0] e;
      wait_de(de, 40);
      e = exp_q.pop_front();
      check(name, 32'(sym_out), 32'(e));
   endtask

   // Called positioned at a negedge; returns at the negedge after acceptance.
   task automatic do_write(input logic [1:0] a, input logic [SYM_W-1:0] s, output int stalls);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_sym   = s;
      stalls   = 0;
      while (!wr_ready && stalls < 5) begin
         @(negedge clk);
         stalls++;
      end
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int n;
      int stalls;
      int err_pulses;
      int ticks2;
      bit sym2_nonzero;
      bit bad_sel2;

      rst_n = 1'b0; en = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_sym = '0;
      en2 = 1'b0; wr_valid2 = 1'b0; wr_addr2 = '0; wr_sym2 = '0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_digit_en",  32'(digit_en),   32'd0);
      check("rst_sym_out",   32'(sym_out),    32'd0);
      check("rst_scan_idx",  32'(scan_idx),   32'd0);
      check("rst_wr_ready",  32'(wr_ready),   32'd1);
      check("rst_tick",      32'(frame_tick), 32'd0);
      check("rst_wr_err",    32'(wr_err),     32'd0);
      check("rst_state",     32'(fsm_state),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_no_en", 32'(fsm_state), 32'd0);

      // Enable: 0000 x1, 0001 x3, 0000, 0010 ...
      en = 1'b1;
      @(negedge clk); check("seq_blank0", 32'(digit_en), 32'h0);
      check("seq_blank0_st", 32'(fsm_state), 32'd1);
      @(negedge clk); check("seq_show0a", 32'(digit_en), 32'h1);
      @(negedge clk);
      @(negedge clk); check("seq_show0c", 32'(digit_en), 32'h1);
      @(negedge clk); check("seq_blank1", 32'(digit_en), 32'h0);
      @(negedge clk); check("seq_show1a", 32'(digit_en), 32'h2);
      check("seq_idx1", 32'(scan_idx), 32'd1);
      wait_tick(20, n); check("first_tick_dist", 32'(n), 32'd11);
      wait_tick(20, n); check("tick_period", 32'(n), 32'd16);

      // Mid-frame write to digit 2: hidden this frame, shown next frame
      repeat (3) @(negedge clk);
      do_write(2'd2, 5'b10110, stalls);
      check("mid_write_stalls", 32'(stalls), 32'd0);
      exp_q.push_back(5'b00000);
      expect_sym(4'b0100, "d2_same_frame");
      wait_tick(20, n);
      exp_q.push_back(5'b10110);
      expect_sym(4'b0100, "d2_next_frame");

      // Write presented in the commit cycle is stalled one cycle
      wait_tick(20, n);
      check("ready_at_tick", 32'(wr_ready), 32'd0);
      do_write(2'd1, 5'b01101, stalls);
      check("commit_stalls", 32'(stalls), 32'd1);
      exp_q.push_back(5'b00000);
      expect_sym(4'b0010, "d1_not_yet");
      wait_tick(20, n);
      exp_q.push_back(5'b01101);
      expect_sym(4'b0010, "d1_one_frame_later");

      // Drop en during SHOW of digit 1 with a pending write to digit 3
      do_write(2'd3, 5'b11100, stalls);
      check("pre_drop_show1", 32'(digit_en), 32'h2);
      en = 1'b0;
      @(negedge clk);
      check("drop_digit_en", 32'(digit_en),   32'h0);
      check("drop_scan_idx", 32'(scan_idx),   32'd0);
      check("drop_no_tick",  32'(frame_tick), 32'd0);
      repeat (4) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      check("reen_state", 32'(fsm_state), 32'd1);
      check("reen_idx",   32'(scan_idx),  32'd0);
      exp_q.push_back(5'b11100);
      expect_sym(4'b1000, "pending_shown_now");

      // Reset mid-frame with a pending write
      do_write(2'd0, 5'b10001, stalls);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_digit_en", 32'(digit_en),  32'd0);
      check("mrst_sym_out",  32'(sym_out),   32'd0);
      check("mrst_scan_idx", 32'(scan_idx),  32'd0);
      check("mrst_state",    32'(fsm_state), 32'd0);
      check("mrst_wr_ready", 32'(wr_ready),  32'd1);
      rst_n = 1'b1;
      exp_q.push_back(5'b00000);
      expect_sym(4'b0001, "mrst_d0_blank");
      exp_q.push_back(5'b00000);
      expect_sym(4'b1000, "mrst_d3_blank");

      // Out-of-range writes on the 5-digit instance
      en2 = 1'b1;
      @(negedge clk);
      check("d2_state", 32'(fsm_state2), 32'd1);
      @(negedge clk);
      check("d2_ready", 32'(wr_ready2), 32'd1);
      wr_valid2 = 1'b1; wr_addr2 = 3'd5; wr_sym2 = 5'b11111;
      @(negedge clk); wr_valid2 = 1'b0;
      check("oor5_err", 32'(wr_err2), 32'd1);
      @(negedge clk);
      check("oor5_err_clear", 32'(wr_err2), 32'd0);
      check("d2_ready_b", 32'(wr_ready2), 32'd1);
      wr_valid2 = 1'b1; wr_addr2 = 3'd7; wr_sym2 = 5'b10101;
      @(negedge clk); wr_valid2 = 1'b0;
      check("oor7_err", 32'(wr_err2), 32'd1);
      err_pulses = 0; ticks2 = 0; sym2_nonzero = 0; bad_sel2 = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (wr_err2) err_pulses++;
         if (frame_tick2) ticks2++;
         if (sym_out2 != '0) sym2_nonzero = 1;
         if (digit_en2 != '0 && digit_en2 != (5'b00001 << scan_idx2)) bad_sel2 = 1;
      end
      check("oor_no_more_err", 32'(err_pulses), 32'd0);
      check("oor_ticks", 32'(ticks2), 32'd2);
      check("oor_buffers_blank", 32'(sym2_nonzero), 32'd0);
      check("d2_select_matches_idx", 32'(bad_sel2), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
